bsg_wormhole_link_splitter: RTL

BSG_WORMHOLE_LINK_SPLITTER -- requirements
Module: bsg_wormhole_link_splitter

---
 rtl/bsg_wormhole_link_splitter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bsg_wormhole_link_splitter.sv
// bsg_wormhole_link_splitter
// Splits one concentrated wormhole link into two channel links and merges them back.
module bsg_wormhole_link_splitter #(
    parameter int flit_width_p = 32,
    parameter int len_width_p  = 4,
    parameter int cid_width_p  = 4,
    parameter int cord_width_p = 7
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [flit_width_p+1:0]      single_link_i,
    output logic [flit_width_p+1:0]      single_link_o,
    input  logic [1:0][flit_width_p+1:0] links_i,
    output logic [1:0][flit_width_p+1:0] links_o
);

    localparam int link_width_lp = flit_width_p + 2;
    localparam int len_lsb_lp    = cord_width_p;
    localparam int cid_lsb_lp    = cord_width_p + len_width_p;

    typedef enum logic {S_IDLE, S_BUSY} split_state_e;
    typedef enum logic {M_IDLE, M_LOCK} merge_state_e;

    split_state_e            split_state;
    logic                    sel_r;
    logic [len_width_p-1:0]  cnt_r;

    merge_state_e            merge_state;
    logic                    own_r;
    logic                    rr_r;
    logic [len_width_p-1:0]  mcnt_r;

    logic                    s_v;
    logic [flit_width_p-1:0] s_data;
    logic [len_width_p-1:0]  s_len;
    logic [cid_width_p-1:0]  s_cid;
    logic                    s_sel;
    logic                    s_ready;
    logic                    s_hs;
    logic                    unused_cid;

    logic [1:0]              m_vin;
    logic                    m_g;
    logic                    m_v;
    logic [flit_width_p-1:0] m_data;
    logic [len_width_p-1:0]  m_len;
    logic                    m_ready;
    logic                    m_rdy_en;
    logic                    m_hs;

    // Split side: header fields of the concentrated flit
    assign s_v        = single_link_i[link_width_lp-1];
    assign s_data     = single_link_i[link_width_lp-2:1];
    assign s_len      = s_data[len_lsb_lp +: len_width_p];
    assign s_cid      = s_data[cid_lsb_lp +: cid_width_p];
    assign unused_cid = ^s_cid[cid_width_p-1:1];

    // Body flits follow the latched channel, never their own bits
    assign s_sel   = (split_state == S_BUSY) ? sel_r : s_cid[0];
    assign s_ready = ~reset_i & links_i[s_sel][0];
    assign s_hs    = s_v & s_ready;

    assign m_vin[0] = links_i[0][link_width_lp-1];
    assign m_vin[1] = links_i[1][link_width_lp-1];
    assign m_ready  = single_link_i[0];

    // Merge arbitration: locked owner, else round-robin preference
    always_comb begin
        m_g = rr_r;
        m_v = 1'b0;
        if (merge_state == M_LOCK) begin
            m_g = own_r;
            m_v = m_vin[own_r];
        end else if (m_vin[rr_r]) begin
            m_g = rr_r;
            m_v = 1'b1;
        end else begin
            m_g = ~rr_r;
            m_v = m_vin[~rr_r];
        end
    end

    assign m_data   = links_i[m_g][link_width_lp-2:1];
    assign m_len    = m_data[len_lsb_lp +: len_width_p];
    assign m_rdy_en = ~reset_i & m_ready &
                      ((merge_state == M_LOCK) | m_v);
    assign m_hs     = m_v & m_ready;

    // Output link assembly; reset silences every valid and ready
    always_comb begin
        single_link_o = {m_v & ~reset_i, m_data, s_ready};
        links_o[0]    = {s_v & ~s_sel & ~reset_i, s_data, m_rdy_en & ~m_g};
        links_o[1]    = {s_v & s_sel & ~reset_i, s_data, m_rdy_en & m_g};
    end

    // Split FSM: latch channel and flit count on a non-empty header
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            split_state <= S_IDLE;
            sel_r       <= 1'b0;
            cnt_r       <= '0;
        end else if (s_hs) begin
            unique case (split_state)
                S_IDLE: begin
                    if (s_len != '0) begin
                        split_state <= S_BUSY;
                        sel_r       <= s_sel;
                        cnt_r       <= s_len;
                    end
                end
                S_BUSY: begin
                    cnt_r <= cnt_r - len_width_p'(1);
                    if (cnt_r == len_width_p'(1))
                        split_state <= S_IDLE;
                end
            endcase
        end
    end

    // Merge FSM: hold the owner for a whole packet, then flip preference
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            merge_state <= M_IDLE;
            own_r       <= 1'b0;
            rr_r        <= 1'b0;
            mcnt_r      <= '0;
        end else if (m_hs) begin
            unique case (merge_state)
                M_IDLE: begin
                    if (m_len != '0) begin
                        merge_state <= M_LOCK;
                        own_r       <= m_g;
                        mcnt_r      <= m_len;
                    end else begin
                        rr_r <= ~m_g;
                    end
                end
                M_LOCK: begin
                    mcnt_r <= mcnt_r - len_width_p'(1);
                    if (mcnt_r == len_width_p'(1)) begin
                        merge_state <= M_IDLE;
                        rr_r        <= ~own_r;
                    end
                end
            endcase
        end
    end

endmodule
